// File: rtl/sd_bit_serializer.sv
// Parallel-to-serial converter: a 2-entry word FIFO feeding a shift register,
// producing a registered bit stream with per-word completion pulse.
module sd_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy,
  output logic             dbg_state_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
  logic             push;
  logic             pop;

  // Handshake: a word moves on a rising edge where data_valid && data_ready.
  // data_ready depends only on the registered fill level, never on data_valid,
  // so a producer may hold data_valid high and simply wait.
  assign data_ready = (count_q != 2'd2);
  assign push       = data_valid && data_ready;

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;

    // Pops look only at the registered count, so a word pushed into an empty
    // FIFO always waits one edge before it can be loaded.
    case (state_q)
      S_IDLE: begin
        if (count_q != 2'd0) begin
          pop = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          if (count_q != 2'd0) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shreg_d   = mem_q[rd_ptr_q];
      bit_cnt_d = '0;
      rd_ptr_d  = ~rd_ptr_q;
      state_d   = S_SHIFT;
    end

    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Outputs are computed from next state so they register alongside it.
    ser_valid_d = (state_d == S_SHIFT);
    word_done_d = (state_d == S_SHIFT) && (bit_cnt_d == LAST_BIT);
    if (state_d == S_SHIFT) begin
      ser_out_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
    end else begin
      ser_out_d = IDLE_BIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
      if (push) begin
        mem_q[wr_ptr_q] <= data_in;
      end
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign word_done   = word_done_q;
  assign busy        = (state_q == S_SHIFT) || (count_q != 2'd0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sd_bit_serializer.sv
// Directed bench for sd_bit_serializer: MSB-first default instance plus an
// LSB-first, idle-high instance sharing clock and reset.
module tb_sd_bit_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       word_done;
  logic       busy;
  logic       dbg_state;

  logic [7:0] data_in2;
  logic       data_valid2;
  logic       data_ready2;
  logic       ser_out2;
  logic       ser_valid2;
  logic       word_done2;
  logic       busy2;
  logic       dbg_state2;

  int checks;
  int errors;

  sd_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .word_done(word_done), .busy(busy), .dbg_state_o(dbg_state)
  );

  sd_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in2), .data_valid(data_valid2),
    .data_ready(data_ready2), .ser_out(ser_out2), .ser_valid(ser_valid2),
    .word_done(word_done2), .busy(busy2), .dbg_state_o(dbg_state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1; data_valid = 1'b0; data_in = '0;
    data_valid2 = 1'b0; data_in2 = '0;
    #2;
    checks++;
    if (ser_out !== 1'b0 || ser_valid !== 1'b0 || word_done !== 1'b0 ||
        busy !== 1'b0 || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_vals got out=%b vld=%b done=%b busy=%b rdy=%b exp 0 0 0 0 1",
               ser_out, ser_valid, word_done, busy, data_ready);
    end
    checks++;
    if (ser_out2 !== 1'b1 || ser_valid2 !== 1'b0 || data_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_lsb got out=%b vld=%b rdy=%b exp 1 0 1",
               ser_out2, ser_valid2, data_ready2);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // first edge after release must accept
    data_valid = 1'b1; data_in = 8'h81;
    @(posedge clk); #1;
    data_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_accept got busy=%b vld=%b exp busy=1 vld=0", busy, ser_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (ser_valid !== 1'b1 || ser_out !== 1'b1) begin
      errors++;
      $display("FAIL first_bit got vld=%b out=%b exp 1 1", ser_valid, ser_out);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b0 || ser_out !== 1'b0) begin
      errors++;
      $display("FAIL drain_81 got vld=%b busy=%b out=%b exp 0 0 0", ser_valid, busy, ser_out);
    end
  endtask

  task automatic test_single;
    logic [7:0] exp_bits;
    exp_bits = 8'b1101_0110;
    data_valid = 1'b1; data_in = 8'hD6;
    @(posedge clk); #1;
    data_valid = 1'b0; data_in = 8'h00;
    checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency got vld=%b busy=%b exp 0 1", ser_valid, busy);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ser_valid !== 1'b1 || ser_out !== exp_bits[7-i] || word_done !== (i == 7)) begin
        errors++;
        $display("FAIL single_bit idx=%0d got vld=%b out=%b done=%b exp 1 %b %b",
                 i, ser_valid, ser_out, word_done, exp_bits[7-i], (i == 7));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ser_valid !== 1'b0 || ser_out !== 1'b0 || busy !== 1'b0 || word_done !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got vld=%b out=%b busy=%b done=%b exp 0 0 0 0",
               ser_valid, ser_out, busy, word_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_bits;
    exp_bits = 16'b1100_0000_0110_1100;
    data_valid = 1'b1; data_in = 8'hC0;
    @(posedge clk); #1;
    data_in = 8'h6C;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      data_valid = 1'b0;
      checks++;
      if (ser_valid !== 1'b1 || ser_out !== exp_bits[15-i] ||
          word_done !== (i == 7 || i == 15)) begin
        errors++;
        $display("FAIL b2b_bit idx=%0d got vld=%b out=%b done=%b exp 1 %b %b",
                 i, ser_valid, ser_out, word_done, exp_bits[15-i], (i == 7 || i == 15));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got vld=%b busy=%b exp 0 0", ser_valid, busy);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_bits;
    logic        exp_rdy;
    exp_bits = 32'hD6FF_00AA;
    data_valid = 1'b1; data_in = 8'hD6;
    @(posedge clk); #1;
    data_in = 8'hFF;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      exp_rdy = (i == 0) || (i == 8) || (i >= 16);
      checks++;
      if (ser_valid !== 1'b1 || ser_out !== exp_bits[31-i] ||
          word_done !== ((i % 8) == 7) || data_ready !== exp_rdy) begin
        errors++;
        $display("FAIL bp_bit idx=%0d got vld=%b out=%b done=%b rdy=%b exp 1 %b %b %b",
                 i, ser_valid, ser_out, word_done, data_ready,
                 exp_bits[31-i], ((i % 8) == 7), exp_rdy);
      end
      if (i == 0) data_in = 8'h00;
      if (i == 1) data_in = 8'hAA;
      if (i == 9) begin
        data_valid = 1'b0; data_in = 8'h00;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle got vld=%b busy=%b rdy=%b exp 0 0 1", ser_valid, busy, data_ready);
    end
  endtask

  task automatic test_reset_mid_word;
    data_valid = 1'b1; data_in = 8'hD6;
    @(posedge clk); #1;
    data_in = 8'h5A;
    @(posedge clk); #1;
    data_valid = 1'b0; data_in = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ser_valid !== 1'b1 || ser_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_bit4 got vld=%b out=%b exp 1 0", ser_valid, ser_out);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (ser_out !== 1'b0 || ser_valid !== 1'b0 || word_done !== 1'b0 ||
        busy !== 1'b0 || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got out=%b vld=%b done=%b busy=%b rdy=%b exp 0 0 0 0 1",
               ser_out, ser_valid, word_done, busy, data_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ser_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got vld=%b busy=%b exp 0 0", i, ser_valid, busy);
      end
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] exp_bits;
    exp_bits = 8'b1100_0000;
    checks++;
    if (ser_out2 !== 1'b1 || ser_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL lsb_pre got out=%b vld=%b exp 1 0", ser_out2, ser_valid2);
    end
    data_valid2 = 1'b1; data_in2 = 8'h03;
    @(posedge clk); #1;
    data_valid2 = 1'b0; data_in2 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ser_valid2 !== 1'b1 || ser_out2 !== exp_bits[7-i] || word_done2 !== (i == 7)) begin
        errors++;
        $display("FAIL lsb_bit idx=%0d got vld=%b out=%b done=%b exp 1 %b %b",
                 i, ser_valid2, ser_out2, word_done2, exp_bits[7-i], (i == 7));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ser_out2 !== 1'b1 || ser_valid2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL lsb_post got out=%b vld=%b busy=%b exp 1 0 0", ser_out2, ser_valid2, busy2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_lsb_first();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
